// File: rtl/jk_input_conditioner.sv
// jk_input_conditioner
// ---------------------------------------------------------------------------
// Turns two raw, bouncing, clock-asynchronous push-buttons into clean J/K
// levels for a downstream JK flip-flop, plus a rising-edge strobe per channel.
//
// Each channel works the same way and keeps its own state:
//   raw button -> two-flop synchronizer (s1, s2) -> debounce counter -> level
// The debounced level follows s2 only after s2 has disagreed with it on
// DEBOUNCE_CYCLES consecutive clk edges. If s2 agrees with the level on any
// edge, the partial count is thrown away.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to change a level
//                    (1..65535)
//   CNT_W            debounce counter width; 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears all state
//   btn_j    in   raw J button (asynchronous, may bounce)
//   btn_k    in   raw K button (asynchronous, may bounce)
//   J        out  debounced J level
//   K        out  debounced K level
//   jk       out  {J, K}
//   j_pulse  out  high for the single cycle in which J first reads 1
//   k_pulse  out  high for the single cycle in which K first reads 1
//
// Every output is a flop or plain wiring of a flop; nothing combinational
// reaches an output from btn_j or btn_k.
// ---------------------------------------------------------------------------
module jk_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_j,
  input  logic       btn_k,
  output logic       J,
  output logic       K,
  output logic [1:0] jk,
  output logic       j_pulse,
  output logic       k_pulse
);

  // Channel index 1 is J and index 0 is K, so {J, K} is just lvl_q.
  localparam int unsigned NUM_CH = 2;

  // Last count value before the level flips. With DEBOUNCE_CYCLES = 1 this is
  // 0, so a level changes on the first disagreeing edge.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] btn_raw;
  logic [NUM_CH-1:0] s1_q;
  logic [NUM_CH-1:0] s2_q;
  logic [NUM_CH-1:0] lvl_q;
  logic [NUM_CH-1:0] lvl_d;
  logic [NUM_CH-1:0] pulse_q;
  logic [NUM_CH-1:0] pulse_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  assign btn_raw = {btn_j, btn_k};

  // Debounce next-state. The count only moves while s2 disagrees with the
  // level. It clears the moment they agree, and it clears again when the
  // level flips. So it tops out at CNT_MAX and can never wrap.
  always_comb begin
    lvl_d = lvl_q;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = '0;
      if (s2_q[c] != lvl_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          lvl_d[c] = s2_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
    // The strobe is registered together with the level. It is therefore high
    // in exactly the cycle where the new 1 first appears on the output.
    pulse_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign J       = lvl_q[1];
  assign K       = lvl_q[0];
  assign jk      = lvl_q;
  assign j_pulse = pulse_q[1];
  assign k_pulse = pulse_q[0];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Bench for jk_input_conditioner. It drives two instances from the same
// buttons: one with DEBOUNCE_CYCLES = 4 and one with DEBOUNCE_CYCLES = 1.
//
// Reference model: the bench keeps each channel's synchronized samples in a
// history window. A level flips when the most recent D synchronized samples
// all disagree with it.
//
// Inputs change on the falling edge. Outputs are compared on the falling edge.
module tb_jk_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_j = 1'b0;
  logic       btn_k = 1'b0;

  logic       j4, k4, jp4, kp4;
  logic [1:0] jk4;
  logic       j1, k1, jp1, kp1;
  logic [1:0] jk1;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned edge_n = 0;
  logic        jp_seen = 1'b0;
  logic        kp_seen = 1'b0;

  // Model state. Channels: 0 = J/D4, 1 = K/D4, 2 = J/D1, 3 = K/D1.
  logic        m_s1 [4] = '{default: 1'b0};
  logic        m_s2 [4] = '{default: 1'b0};
  logic        m_lvl [4] = '{default: 1'b0};
  logic        m_pulse [4] = '{default: 1'b0};
  logic [15:0] m_hist [4] = '{default: 16'h0};

  jk_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .btn_j(btn_j), .btn_k(btn_k),
    .J(j4), .K(k4), .jk(jk4), .j_pulse(jp4), .k_pulse(kp4)
  );

  jk_input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_j(btn_j), .btn_k(btn_k),
    .J(j1), .K(k1), .jk(jk1), .j_pulse(jp1), .k_pulse(kp1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int dcyc(input int ch);
    return (ch < 2) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_s1[ch] = 1'b0;
      m_s2[ch] = 1'b0;
      m_lvl[ch] = 1'b0;
      m_pulse[ch] = 1'b0;
      m_hist[ch] = 16'h0;
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < 4; ch++) begin
      logic b;
      logic used;
      logic all_diff;
      b = (ch % 2 == 0) ? btn_j : btn_k;
      used = m_s2[ch];
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = b;
      m_hist[ch] = {m_hist[ch][14:0], used};
      all_diff = 1'b1;
      for (int i = 0; i < dcyc(ch); i++) begin
        if (m_hist[ch][i] == m_lvl[ch]) all_diff = 1'b0;
      end
      m_pulse[ch] = 1'b0;
      if (all_diff) begin
        m_lvl[ch] = ~m_lvl[ch];
        m_pulse[ch] = m_lvl[ch];
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("J4", j4, m_lvl[0]);
    check_val("K4", k4, m_lvl[1]);
    check_val("jk4", jk4, {m_lvl[0], m_lvl[1]});
    check_val("j_pulse4", jp4, m_pulse[0]);
    check_val("k_pulse4", kp4, m_pulse[1]);
    check_val("J1", j1, m_lvl[2]);
    check_val("K1", k1, m_lvl[3]);
    check_val("jk1", jk1, {m_lvl[2], m_lvl[3]});
    check_val("j_pulse1", jp1, m_pulse[2]);
    check_val("k_pulse1", kp1, m_pulse[3]);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: the model follows the rising edge, and the outputs are
  // compared on the falling edge. The caller drives new inputs after return.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    check_outputs();
    jp_seen = jp_seen | jp4;
    kp_seen = kp_seen | kp4;
  endtask

  function automatic logic out_sel(input int sel);
    case (sel)
      0: return j4;
      1: return k4;
      2: return j1;
      default: return k1;
    endcase
  endfunction

  // Counts rising edges until the selected output reaches the target level.
  // The wait is bounded; on timeout it reports a sentinel value.
  task automatic wait_level(input string tag, input int sel, input logic target,
                            input int unsigned exp_edges);
    int unsigned e0;
    logic seen;
    e0 = edge_n;
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      tick();
      if (out_sel(sel) == target) seen = 1'b1;
    end
    check_val(tag, seen ? (edge_n - e0) : 32'hDEAD, exp_edges);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rate;
    logic [4:0] bounce;

    // Reset state, checked before any clock edge.
    #1;
    check_outputs();
    check_val("reset_jk", jk4, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // A clean J press: J and j_pulse appear on the 6th edge, and K stays 0.
    jp_seen = 1'b0;
    btn_j = 1'b1;
    wait_level("j_rise_latency", 0, 1'b1, 6);
    check_val("j_pulse_on_rise", jp4, 1'b1);
    check_val("jk_j_only", jk4, 2'b10);
    tick();
    check_val("j_pulse_one_cycle", jp4, 1'b0);
    check_val("k_stays_low", k4, 1'b0);

    // A K press that lasts only 3 cycles is filtered out.
    kp_seen = 1'b0;
    btn_k = 1'b1;
    repeat (3) tick();
    btn_k = 1'b0;
    repeat (12) tick();
    check_val("k_short_no_pulse", kp_seen, 1'b0);
    check_val("k_short_level", k4, 1'b0);

    // Releasing J: J falls after 6 edges, and the fall gives no strobe.
    jp_seen = 1'b0;
    btn_j = 1'b0;
    wait_level("j_fall_latency", 0, 1'b0, 6);
    repeat (2) tick();
    check_val("j_fall_no_pulse", jp_seen, 1'b0);

    // J bounces 1,0,1,1,0 and then holds at 1. The bounce must not count.
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn_j = bounce[i];
      tick();
      check_val("j_during_bounce", j4, 1'b0);
    end
    btn_j = 1'b1;
    wait_level("j_after_bounce", 0, 1'b1, 6);
    btn_j = 1'b0;
    wait_level("j_fall_again", 0, 1'b0, 6);

    // J and K pressed together rise together, and both strobes fire together.
    btn_j = 1'b1;
    btn_k = 1'b1;
    for (int i = 0; i < 20 && !(j4 | k4); i++) tick();
    check_val("jk_same_edge", {j4, k4}, 2'b11);
    check_val("pulses_same_cycle", {jp4, kp4}, 2'b11);
    check_val("jk_both", jk4, 2'b11);
    btn_j = 1'b0;
    btn_k = 1'b0;
    wait_level("jk_fall", 0, 1'b0, 6);

    // A reset in the middle of a count throws the partial count away.
    btn_j = 1'b1;
    repeat (5) tick();
    assert_reset();
    check_val("rst_async_jk", jk4, 2'b00);
    check_val("rst_async_pulses", {jp4, kp4}, 2'b00);
    tick();
    check_val("rst_held_J", j4, 1'b0);
    rst_n = 1'b1;
    wait_level("j_after_reset", 0, 1'b1, 6);
    btn_j = 1'b0;
    wait_level("j_clear", 0, 1'b0, 6);

    // With DEBOUNCE_CYCLES = 1, the level changes on the first disagreeing edge.
    btn_k = 1'b1;
    wait_level("k_d1_latency", 3, 1'b1, 3);
    btn_k = 1'b0;
    repeat (8) tick();

    // Random bouncing with an occasional reset.
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        tick();
        rst_n = 1'b1;
      end
      rate = ((i / 250) % 2 == 1) ? 2 : 9;
      if ($urandom_range(0, rate) == 0) btn_j = ~btn_j;
      if ($urandom_range(0, rate) == 0) btn_k = ~btn_k;
    end
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_input_conditioner.md
JK_INPUT_CONDITIONER -- requirements
Module: jk_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive clk cycles a synchronized input must differ from its debounced level before that level changes; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each debounce counter; it SHALL satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_j  input  1  raw push-button for J; asynchronous to clk and may bounce.
REQ-006 SHALL have port btn_k  input  1  raw push-button for K; asynchronous to clk and may bounce.
REQ-007 SHALL have port J  output  1  debounced J level that drives the downstream JK flip-flop J input.
REQ-008 SHALL have port K  output  1  debounced K level that drives the downstream JK flip-flop K input.
REQ-009 SHALL have port jk  output  2  packed {J,K}: J on bit 1, K on bit 0.
REQ-010 SHALL have port j_pulse  output  1  one-cycle strobe on each rising edge of J.
REQ-011 SHALL have port k_pulse  output  1  one-cycle strobe on each rising edge of K.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-013 The J and K channels SHALL be identical and fully independent, with no shared counter or state.
REQ-014 Per channel, on each clk edge where s2 equals the debounced level, the counter SHALL clear to 0.
REQ-015 Per channel, on each clk edge where s2 differs from the debounced level and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-016 Per channel, on each clk edge where s2 differs from the debounced level and cnt == DEBOUNCE_CYCLES-1, the debounced level SHALL take the value of s2 and cnt SHALL clear to 0.
REQ-017 A clean button transition held stable SHALL change the debounced level on the (DEBOUNCE_CYCLES+2)th rising clk edge after the transition, assuming setup time is met.
REQ-018 A synchronized excursion shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced level and SHALL restart the count.
REQ-019 The counter SHALL never wrap; its maximum reachable value is DEBOUNCE_CYCLES-1.
REQ-020 j_pulse SHALL be high for exactly the one cycle following the edge on which J goes from 0 to 1, i.e. in the same cycle J first reads 1; k_pulse SHALL behave identically for K.
REQ-021 Falling edges of J or K SHALL produce no pulse.
REQ-022 Simultaneous transitions on btn_j and btn_k SHALL be debounced in parallel, so that J and K change on the same edge and both pulses are asserted together.
REQ-023 With DEBOUNCE_CYCLES=1, a level change SHALL occur on the first edge on which s2 differs from the debounced level.
REQ-024 All outputs SHALL be registered or direct wiring of registers, with no combinational path from btn_j or btn_k to any output.

Reset
REQ-025 While rst_n=0, s1, s2, cnt, J, K, j_pulse and k_pulse SHALL all be 0 immediately, independent of clk.
REQ-026 After rst_n deasserts, the block SHALL resume counting from 0 on the next clk edge.
REQ-027 Asserting rst_n mid-count SHALL discard the partial count, so that after release a fresh full DEBOUNCE_CYCLES interval is required.

Verification
REQ-028 The bench SHALL cover: DEBOUNCE_CYCLES=4, btn_j 0->1 held -> J=1 and j_pulse=1 for one cycle, both appearing on the 6th edge; K stays 0; jk=2'b10.
REQ-029 The bench SHALL cover: btn_k pulsed high for 3 cycles then low -> K stays 0; k_pulse never asserts.
REQ-030 The bench SHALL cover: btn_j bouncing 1,0,1,1,0 at one-cycle spacing, then steady 1 -> J rises only after 4 consecutive synchronized 1s.
REQ-031 The bench SHALL cover: btn_j and btn_k rising on the same edge -> J and K rise on the same edge; jk=2'b11; both pulses assert in the same cycle.
REQ-032 The bench SHALL cover: btn_j=1, rst_n pulsed low after 3 counted cycles -> all outputs 0 during reset; J rises on the 4th counted edge after release.
REQ-033 The bench SHALL cover: J=1 then btn_j 1->0 held -> J falls after 6 edges; j_pulse stays 0.
